// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command controller: opcodes, operand
// register addresses and the one-hot parser state encoding.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam int unsigned OPA_ADDR = 0;
    localparam int unsigned OPB_ADDR = 1;

    localparam int unsigned STATE_W = 12;

    typedef enum logic [STATE_W-1:0] {
        IDLE     = 12'b0000_0000_0001,
        WR_ADDR  = 12'b0000_0000_0010,
        WR_DATA  = 12'b0000_0000_0100,
        RD_ADDR  = 12'b0000_0000_1000,
        RD_WAIT  = 12'b0000_0001_0000,
        OP_A     = 12'b0000_0010_0000,
        OP_B     = 12'b0000_0100_0000,
        FUN      = 12'b0000_1000_0000,
        ALU_WAIT = 12'b0001_0000_0000,
        TX_RD    = 12'b0010_0000_0000,
        TX_LO    = 12'b0100_0000_0000,
        TX_HI    = 12'b1000_0000_0000
    } state_t;

endpackage

// File: rtl/uart_cmd_tx_mux.sv
// Response byte selector: picks the byte for the current TX state and
// qualifies the FIFO write strobe with FIFO_FULL in the same cycle.
module uart_cmd_tx_mux
    import uart_cmd_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  state_t               state,
    input  logic [WIDTH-1:0]     rd_data,
    input  logic [2*WIDTH-1:0]   result,
    input  logic                 fifo_full,
    output logic [WIDTH-1:0]     tx_data_c,
    output logic                 tx_vld_c
);

    // Strobe must never coincide with FIFO_FULL, so it cannot be delayed a cycle.
    always_comb begin
        tx_data_c = '0;
        tx_vld_c  = 1'b0;
        case (state)
            TX_RD: begin
                tx_data_c = rd_data;
                tx_vld_c  = ~fifo_full;
            end
            TX_LO: begin
                tx_data_c = result[WIDTH-1:0];
                tx_vld_c  = ~fifo_full;
            end
            TX_HI: begin
                tx_data_c = result[2*WIDTH-1:WIDTH];
                tx_vld_c  = ~fifo_full;
            end
            default: begin
                tx_data_c = '0;
                tx_vld_c  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command controller: parses received byte frames into register-file
// and ALU operations and queues the response bytes into the TX FIFO.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ALU_FUN_W = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  PAR_ERR,
    input  logic                  STP_ERR,
    output logic                  RF_WrEn,
    output logic                  RF_RdEn,
    output logic [ADDR_W-1:0]     RF_Address,
    output logic [WIDTH-1:0]      RF_WrData,
    input  logic [WIDTH-1:0]      RF_RdData,
    input  logic                  RF_RdData_VLD,
    output logic                  ALU_EN,
    output logic [ALU_FUN_W-1:0]  ALU_FUN,
    output logic                  CLK_EN,
    input  logic [2*WIDTH-1:0]    ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [WIDTH-1:0]      TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  FIFO_FULL
);

    state_t               state, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]     rd_data_q, rd_data_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 wr_en_d, rd_en_d, alu_en_d, clk_en_d;
    logic [ADDR_W-1:0]    address_d;
    logic [WIDTH-1:0]     wr_data_d;
    logic [ALU_FUN_W-1:0] alu_fun_d;
    logic                 byte_ok_c, byte_err_c;

    assign byte_ok_c  = RX_D_VLD & ~PAR_ERR & ~STP_ERR;
    assign byte_err_c = RX_D_VLD & (PAR_ERR | STP_ERR);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            addr_q     <= '0;
            rd_data_q  <= '0;
            result_q   <= '0;
            RF_WrEn    <= 1'b0;
            RF_RdEn    <= 1'b0;
            RF_Address <= '0;
            RF_WrData  <= '0;
            ALU_EN     <= 1'b0;
            ALU_FUN    <= '0;
            CLK_EN     <= 1'b0;
        end else begin
            state      <= state_d;
            addr_q     <= addr_d;
            rd_data_q  <= rd_data_d;
            result_q   <= result_d;
            RF_WrEn    <= wr_en_d;
            RF_RdEn    <= rd_en_d;
            RF_Address <= address_d;
            RF_WrData  <= wr_data_d;
            ALU_EN     <= alu_en_d;
            ALU_FUN    <= alu_fun_d;
            CLK_EN     <= clk_en_d;
        end
    end

    // Next-state and registered-output decode; strobes are computed one cycle early.
    always_comb begin
        state_d   = state;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
        result_d  = result_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        address_d = RF_Address;
        wr_data_d = RF_WrData;
        alu_fun_d = ALU_FUN;

        case (state)
            IDLE: begin
                if (byte_ok_c) begin
                    if (RX_P_DATA == WIDTH'(CMD_RF_WR))        state_d = WR_ADDR;
                    else if (RX_P_DATA == WIDTH'(CMD_RF_RD))   state_d = RD_ADDR;
                    else if (RX_P_DATA == WIDTH'(CMD_ALU_OP))  state_d = OP_A;
                    else if (RX_P_DATA == WIDTH'(CMD_ALU_NOP)) state_d = FUN;
                    else                                       state_d = IDLE;
                end
            end
            WR_ADDR: begin
                if (byte_ok_c) begin
                    addr_d  = RX_P_DATA[ADDR_W-1:0];
                    state_d = WR_DATA;
                end
            end
            WR_DATA: begin
                if (byte_ok_c) begin
                    wr_en_d   = 1'b1;
                    address_d = addr_q;
                    wr_data_d = RX_P_DATA;
                    state_d   = IDLE;
                end
            end
            RD_ADDR: begin
                if (byte_ok_c) begin
                    rd_en_d   = 1'b1;
                    address_d = RX_P_DATA[ADDR_W-1:0];
                    state_d   = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (RF_RdData_VLD) begin
                    rd_data_d = RF_RdData;
                    state_d   = TX_RD;
                end
            end
            OP_A: begin
                if (byte_ok_c) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_W'(OPA_ADDR);
                    wr_data_d = RX_P_DATA;
                    state_d   = OP_B;
                end
            end
            OP_B: begin
                if (byte_ok_c) begin
                    wr_en_d   = 1'b1;
                    address_d = ADDR_W'(OPB_ADDR);
                    wr_data_d = RX_P_DATA;
                    state_d   = FUN;
                end
            end
            FUN: begin
                if (byte_ok_c) begin
                    alu_fun_d = RX_P_DATA[ALU_FUN_W-1:0];
                    state_d   = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_d = ALU_OUT;
                    state_d  = TX_LO;
                end
            end
            TX_RD:   if (TX_D_VLD) state_d = IDLE;
            TX_LO:   if (TX_D_VLD) state_d = TX_HI;
            TX_HI:   if (TX_D_VLD) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A corrupted frame abandons any partially parsed command.
        if (byte_err_c && (state inside {WR_ADDR, WR_DATA, RD_ADDR, OP_A, OP_B, FUN})) begin
            state_d = IDLE;
        end

        alu_en_d = (state_d == ALU_WAIT);
        clk_en_d = (state_d inside {ALU_WAIT, TX_LO, TX_HI});
    end

    uart_cmd_tx_mux #(
        .WIDTH (WIDTH)
    ) u_tx_mux (
        .state     (state),
        .rd_data   (rd_data_q),
        .result    (result_q),
        .fifo_full (FIFO_FULL),
        .tx_data_c (TX_P_DATA),
        .tx_vld_c  (TX_D_VLD)
    );

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: bench-side register file and ALU,
// command-level reference model, directed and randomized scenarios.
module tb_uart_cmd_ctrl;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned ALU_FUN_W = 4;

    logic                  CLK_tb = 1'b0;
    logic                  RST;
    logic [WIDTH-1:0]      RX_P_DATA;
    logic                  RX_D_VLD;
    logic                  PAR_ERR;
    logic                  STP_ERR;
    logic                  RF_WrEn;
    logic                  RF_RdEn;
    logic [ADDR_W-1:0]     RF_Address;
    logic [WIDTH-1:0]      RF_WrData;
    logic [WIDTH-1:0]      RF_RdData;
    logic                  RF_RdData_VLD;
    logic                  ALU_EN;
    logic [ALU_FUN_W-1:0]  ALU_FUN;
    logic                  CLK_EN;
    logic [2*WIDTH-1:0]    ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic [WIDTH-1:0]      TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  FIFO_FULL;

    logic [28:0] outs;
    assign outs = {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_EN, TX_P_DATA, TX_D_VLD};

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    logic [WIDTH-1:0]        mem    [16];
    logic [WIDTH-1:0]        ref_rf [16];
    logic [ADDR_W+WIDTH-1:0] wr_q [$];
    logic [ADDR_W-1:0]       rd_q [$];
    logic [WIDTH-1:0]        tx_q [$];

    always #5 CLK_tb = ~CLK_tb;

    uart_cmd_ctrl #(
        .WIDTH(WIDTH), .ADDR_W(ADDR_W), .ALU_FUN_W(ALU_FUN_W)
    ) dut (
        .CLK(CLK_tb), .RST(RST),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR),
        .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address), .RF_WrData(RF_WrData),
        .RF_RdData(RF_RdData), .RF_RdData_VLD(RF_RdData_VLD),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .FIFO_FULL(FIFO_FULL)
    );

    // Bench register file plus event capture, sampled mid-cycle.
    always @(negedge CLK_tb) begin
        if (RST === 1'b1) begin
            if (RF_WrEn) begin
                wr_q.push_back({RF_Address, RF_WrData});
                mem[RF_Address] = RF_WrData;
            end
            if (RF_RdEn) rd_q.push_back(RF_Address);
            if (TX_D_VLD) tx_q.push_back(TX_P_DATA);
            if (RF_WrEn && RF_RdEn) viol++;
            if (TX_D_VLD && FIFO_FULL) viol++;
            if (ALU_EN && !CLK_EN) viol++;
        end
    end

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        case (f)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) - 16'(b);
            4'd2:    return 16'(a) * 16'(b);
            4'd3:    return {8'h00, a & b};
            default: return {a, b} ^ 16'h5AC3;
        endcase
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
        @(posedge CLK_tb); #1;
        RX_P_DATA = b; PAR_ERR = pe; STP_ERR = se; RX_D_VLD = 1'b1;
        @(posedge CLK_tb); #1;
        RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0; RX_P_DATA = 8'($urandom);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        logic [11:0] exp;
        wr_q.delete(); tx_q.delete();
        exp = {a[3:0], d};
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        send_byte(d, 1'b0, 1'b0);
        ref_rf[a[3:0]] = d;
        repeat (3) @(posedge CLK_tb); #1;
        checks++;
        if (wr_q.size() != 1 || wr_q[0] !== exp) begin
            errors++;
            $display("FAIL rf_write got n=%0d first=%h want n=1 %h", wr_q.size(),
                     (wr_q.size() > 0) ? wr_q[0] : 12'h000, exp);
        end
        checks++;
        if (tx_q.size() != 0 || RF_WrEn !== 1'b0) begin
            errors++;
            $display("FAIL write_side_effects got tx=%0d wren=%b want tx=0 wren=0", tx_q.size(), RF_WrEn);
        end
    endtask

    task automatic do_read(input logic [7:0] a, input int delay);
        int k;
        wr_q.delete(); rd_q.delete(); tx_q.delete();
        send_byte(8'hBB, 1'b0, 1'b0);
        send_byte(a, 1'b0, 1'b0);
        k = 0;
        while (rd_q.size() == 0 && k < 10) begin @(posedge CLK_tb); #1; k++; end
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== a[3:0]) begin
            errors++;
            $display("FAIL rf_read_strobe got n=%0d want n=1 addr=%h", rd_q.size(), a[3:0]);
        end
        // A stray opcode while the read is outstanding must be ignored.
        send_byte(8'hAA, 1'b0, 1'b0);
        repeat (delay) @(posedge CLK_tb); #1;
        RF_RdData = mem[RF_Address]; RF_RdData_VLD = 1'b1;
        @(posedge CLK_tb); #1;
        RF_RdData_VLD = 1'b0; RF_RdData = 8'($urandom);
        k = 0;
        while (tx_q.size() < 1 && k < 20) begin @(posedge CLK_tb); #1; k++; end
        repeat (4) @(posedge CLK_tb); #1;
        checks++;
        if (tx_q.size() != 1 || tx_q[0] !== ref_rf[a[3:0]]) begin
            errors++;
            $display("FAIL read_response got n=%0d first=%h want n=1 %h", tx_q.size(),
                     (tx_q.size() > 0) ? tx_q[0] : 8'h00, ref_rf[a[3:0]]);
        end
        checks++;
        if (wr_q.size() != 0 || rd_q.size() != 1) begin
            errors++;
            $display("FAIL read_side_effects got wr=%0d rd=%0d want wr=0 rd=1", wr_q.size(), rd_q.size());
        end
    endtask

    // full_mode: 0 none, >0 FIFO full for that many cycles, <0 random toggling.
    task automatic do_alu(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun, input int full_mode);
        logic [15:0] exp;
        int k;
        wr_q.delete(); tx_q.delete();
        if (with_ops) begin
            send_byte(8'hCC, 1'b0, 1'b0);
            send_byte(a, 1'b0, 1'b0);
            send_byte(b, 1'b0, 1'b0);
            ref_rf[0] = a; ref_rf[1] = b;
        end else begin
            send_byte(8'hDD, 1'b0, 1'b0);
        end
        send_byte(fun, 1'b0, 1'b0);
        exp = alu_ref(ref_rf[0], ref_rf[1], fun[3:0]);
        if (with_ops) begin
            checks++;
            if (wr_q.size() != 2 || wr_q[0] !== {4'h0, a} || wr_q[1] !== {4'h1, b}) begin
                errors++;
                $display("FAIL operand_writes got n=%0d want 0:%h 1:%h", wr_q.size(), a, b);
            end
        end
        k = 0;
        while (ALU_EN !== 1'b1 && k < 10) begin @(posedge CLK_tb); #1; k++; end
        checks++;
        if (ALU_EN !== 1'b1 || CLK_EN !== 1'b1 || ALU_FUN !== fun[3:0]) begin
            errors++;
            $display("FAIL alu_start got en=%b clk_en=%b fun=%h want 1 1 %h", ALU_EN, CLK_EN, ALU_FUN, fun[3:0]);
        end
        repeat ($urandom_range(0, 3)) @(posedge CLK_tb);
        #1;
        checks++;
        if (ALU_EN !== 1'b1 || ALU_FUN !== fun[3:0]) begin
            errors++;
            $display("FAIL alu_hold got en=%b fun=%h want 1 %h", ALU_EN, ALU_FUN, fun[3:0]);
        end
        ALU_OUT = alu_ref(mem[0], mem[1], ALU_FUN); ALU_OUT_VLD = 1'b1;
        FIFO_FULL = (full_mode > 0);
        @(posedge CLK_tb); #1;
        ALU_OUT_VLD = 1'b0; ALU_OUT = 16'($urandom);
        if (full_mode > 0) begin
            repeat (full_mode) @(posedge CLK_tb);
            #1;
            checks++;
            if (tx_q.size() != 0 || ALU_EN !== 1'b0 || CLK_EN !== 1'b1) begin
                errors++;
                $display("FAIL backpressure_hold got tx=%0d en=%b clk_en=%b want 0 0 1", tx_q.size(), ALU_EN, CLK_EN);
            end
            FIFO_FULL = 1'b0;
        end
        k = 0;
        while (tx_q.size() < 2 && k < 60) begin
            if (full_mode < 0) FIFO_FULL = 1'($urandom_range(0, 1));
            @(posedge CLK_tb); #1; k++;
        end
        FIFO_FULL = 1'b0;
        repeat (3) @(posedge CLK_tb); #1;
        checks++;
        if (tx_q.size() != 2 || tx_q[0] !== exp[7:0] || tx_q[1] !== exp[15:8]) begin
            errors++;
            $display("FAIL alu_response got n=%0d b0=%h b1=%h want %h %h", tx_q.size(),
                     (tx_q.size() > 0) ? tx_q[0] : 8'h00, (tx_q.size() > 1) ? tx_q[1] : 8'h00, exp[7:0], exp[15:8]);
        end
        checks++;
        if (ALU_EN !== 1'b0 || CLK_EN !== 1'b0) begin
            errors++;
            $display("FAIL alu_release got en=%b clk_en=%b want 0 0", ALU_EN, CLK_EN);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; RX_P_DATA = '0; RX_D_VLD = 1'b0; PAR_ERR = 1'b0; STP_ERR = 1'b0;
        RF_RdData = '0; RF_RdData_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; FIFO_FULL = 1'b0;
        #3;
        checks++;
        if (outs !== 29'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
        repeat (2) @(posedge CLK_tb); #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK_tb); #1;
        checks++;
        if (outs !== 29'h0) begin errors++; $display("FAIL post_reset_idle got %h want 0", outs); end
    endtask

    task automatic test_reg_write();
        do_write(8'h05, 8'h3C);
        do_write(8'hF7, 8'hA5);
    endtask

    task automatic test_reg_read();
        do_read(8'h05, 2);
        do_read(8'h07, 0);
    endtask

    task automatic test_alu_ops();
        do_alu(1'b1, 8'h12, 8'h34, 8'h00, 0);
        do_alu(1'b0, 8'h00, 8'h00, 8'hF2, 0);
    endtask

    task automatic test_backpressure();
        do_alu(1'b1, 8'h12, 8'h34, 8'h00, 10);
        do_alu(1'b1, 8'hFF, 8'hFF, 8'h02, -1);
    endtask

    task automatic test_error_abort();
        wr_q.delete();
        send_byte(8'hAA, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h99, 1'b1, 1'b0);
        repeat (3) @(posedge CLK_tb); #1;
        checks++;
        if (wr_q.size() != 0) begin errors++; $display("FAIL par_err_abort got writes=%0d want 0", wr_q.size()); end
        do_read(8'h05, 2);
        send_byte(8'hDD, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b1);
        repeat (4) @(posedge CLK_tb); #1;
        checks++;
        if (ALU_EN !== 1'b0 || CLK_EN !== 1'b0) begin
            errors++; $display("FAIL stp_err_abort got en=%b clk_en=%b want 0 0", ALU_EN, CLK_EN);
        end
        wr_q.delete();
        send_byte(8'hAA, 1'b0, 1'b1);
        send_byte(8'h05, 1'b0, 1'b0);
        send_byte(8'h3C, 1'b0, 1'b0);
        repeat (3) @(posedge CLK_tb); #1;
        checks++;
        if (wr_q.size() != 0) begin errors++; $display("FAIL err_opcode_dropped got writes=%0d want 0", wr_q.size()); end
        do_write(8'h09, 8'h5E);
    endtask

    task automatic test_reset_mid_op();
        int k;
        send_byte(8'hDD, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        k = 0;
        while (ALU_EN !== 1'b1 && k < 10) begin @(posedge CLK_tb); #1; k++; end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (outs !== 29'h0) begin errors++; $display("FAIL async_reset got %h want 0", outs); end
        repeat (2) @(posedge CLK_tb); #1;
        RST = 1'b1;
        do_alu(1'b0, 8'h00, 8'h00, 8'h02, 0);
        wr_q.delete(); rd_q.delete(); tx_q.delete();
        send_byte(8'h77, 1'b0, 1'b0);
        repeat (10) @(posedge CLK_tb); #1;
        checks++;
        if (wr_q.size() + rd_q.size() + tx_q.size() != 0 || ALU_EN !== 1'b0) begin
            errors++;
            $display("FAIL unknown_opcode got wr=%0d rd=%0d tx=%0d en=%b want all 0",
                     wr_q.size(), rd_q.size(), tx_q.size(), ALU_EN);
        end
    endtask

    task automatic test_random();
        logic [7:0] junk;
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 4))
                0: do_write(8'($urandom), 8'($urandom));
                1: do_read(8'($urandom), $urandom_range(0, 4));
                2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 2) == 0 ? -1 : $urandom_range(0, 5));
                3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), $urandom_range(0, 3));
                default: begin
                    junk = 8'($urandom);
                    while (junk == 8'hAA || junk == 8'hBB || junk == 8'hCC || junk == 8'hDD) junk = 8'($urandom);
                    wr_q.delete(); rd_q.delete(); tx_q.delete();
                    send_byte(junk, 1'b0, 1'b0);
                    repeat (4) @(posedge CLK_tb); #1;
                    checks++;
                    if (wr_q.size() + rd_q.size() + tx_q.size() != 0 || ALU_EN !== 1'b0) begin
                        errors++;
                        $display("FAIL junk_byte %h got events=%0d want 0", junk, wr_q.size() + rd_q.size() + tx_q.size());
                    end
                end
            endcase
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL protocol_violations got %0d want 0", viol); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]    = 8'($urandom);
            ref_rf[i] = mem[i];
        end
        test_reset();
        test_reg_write();
        test_reg_read();
        test_alu_ops();
        test_backpressure();
        test_error_abort();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
